apb_req_master: RTL

APB_REQ_MASTER -- requirements
Module: apb_req_master

---
 rtl/apb_req_master.sv | 126 ++++++++++++
 1 files changed

// File: rtl/apb_req_master.sv
// APB requester: turns a core-side req/gnt/rvalid handshake into single
// outstanding APB transfers, with an optional ACCESS-phase timeout.
module apb_req_master #(
    parameter int unsigned APB_ADDR_WIDTH = 32,
    parameter int unsigned APB_DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req_i,
    input  logic [APB_ADDR_WIDTH-1:0] addr_i,
    input  logic                      we_i,
    input  logic [APB_DATA_WIDTH-1:0] wdata_i,
    output logic                      gnt_o,
    output logic                      rvalid_o,
    output logic [APB_DATA_WIDTH-1:0] rdata_o,
    output logic                      err_o,
    output logic [APB_ADDR_WIDTH-1:0] paddr_o,
    output logic [APB_DATA_WIDTH-1:0] pwdata_o,
    output logic                      pwrite_o,
    output logic                      psel_o,
    output logic                      penable_o,
    input  logic [APB_DATA_WIDTH-1:0] prdata_i,
    input  logic                      pready_i,
    input  logic                      pslverr_i
);

    localparam int unsigned CNT_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit          TO_EN  = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t                    state, state_d;
    logic [CNT_W-1:0]          cnt, cnt_d;
    logic [APB_ADDR_WIDTH-1:0] paddr_d;
    logic [APB_DATA_WIDTH-1:0] pwdata_d, rdata_d;
    logic                      pwrite_d, psel_d, penable_d, rvalid_d, err_d;
    logic                      grant;

    // Grant is combinational so a RESP cycle can accept the next request.
    assign grant = rst_n & req_i & ((state == IDLE) | (state == RESP));
    assign gnt_o = grant;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            paddr_o   <= '0;
            pwdata_o  <= '0;
            pwrite_o  <= 1'b0;
            psel_o    <= 1'b0;
            penable_o <= 1'b0;
            rvalid_o  <= 1'b0;
            rdata_o   <= '0;
            err_o     <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            paddr_o   <= paddr_d;
            pwdata_o  <= pwdata_d;
            pwrite_o  <= pwrite_d;
            psel_o    <= psel_d;
            penable_o <= penable_d;
            rvalid_o  <= rvalid_d;
            rdata_o   <= rdata_d;
            err_o     <= err_d;
        end
    end

    // Next state plus the values every registered output takes in that state.
    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        paddr_d   = paddr_o;
        pwdata_d  = pwdata_o;
        pwrite_d  = pwrite_o;
        psel_d    = 1'b0;
        penable_d = 1'b0;
        rvalid_d  = 1'b0;
        rdata_d   = rdata_o;
        err_d     = err_o;

        case (state)
            IDLE, RESP: begin
                if (grant) begin
                    state_d  = SETUP;
                    paddr_d  = addr_i;
                    pwrite_d = we_i;
                    pwdata_d = wdata_i;
                    psel_d   = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                psel_d    = 1'b1;
                penable_d = 1'b1;
                cnt_d     = '0;
            end
            ACCESS: begin
                if (pready_i) begin
                    state_d  = RESP;
                    rvalid_d = 1'b1;
                    rdata_d  = pwrite_o ? '0 : prdata_i;
                    err_d    = pslverr_i;
                end else if (TO_EN && (cnt == TO_VAL)) begin
                    state_d  = RESP;
                    rvalid_d = 1'b1;
                    rdata_d  = '0;
                    err_d    = 1'b1;
                end else begin
                    psel_d    = 1'b1;
                    penable_d = 1'b1;
                    if (cnt != CNT_MAX) begin
                        cnt_d = cnt + CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
